// File: rtl/score_keeper.sv
// Basket scoring stage: sensor synchronizer/debouncer, game FSM and BCD score.
// Define GAME_TIMER_EN to build the per-second prescaler, TIME_LEFT countdown and OVER state.
module score_keeper #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned GAME_SECONDS    = 60
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       START,
  input  logic       SENSOR,
  output logic [7:0] SCORE,
  output logic [7:0] TIME_LEFT,
  output logic       PLAYING,
  output logic       BASKET
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [7:0] GAME_BCD = 8'(((GAME_SECONDS / 10) << 4) | (GAME_SECONDS % 10));

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER
  } state_t;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd0) begin
      r[3:0] = 4'd9;
      r[7:4] = v[7:4] - 4'd1;
    end else begin
      r[3:0] = v[3:0] - 4'd1;
    end
    return r;
  endfunction

  logic [1:0]    sync;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] deb_cnt;
  logic          basket_evt;

  state_t        state, state_n;
  logic [7:0]    score_n;
  logic          basket_n;

  // The counter flips the level once it has seen DEBOUNCE_CYCLES differing samples.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sync    <= '0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync  <= {sync[0], SENSOR};
      deb_q <= deb;
      if (deb_cnt == CW'(DEBOUNCE_CYCLES)) begin
        deb     <= ~deb;
        deb_cnt <= '0;
      end else if (sync[1] == deb) begin
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign basket_evt = deb & ~deb_q;

`ifdef GAME_TIMER_EN
  localparam int unsigned PW = $clog2(CLK_HZ + 1);

  logic [PW-1:0] presc, presc_n;
  logic [7:0]    time_n;

  always_comb begin
    state_n  = state;
    score_n  = SCORE;
    basket_n = 1'b0;
    presc_n  = presc;
    time_n   = TIME_LEFT;
    case (state)
      IDLE, OVER: begin
        if (START) begin
          state_n = PLAY;
          score_n = '0;
          presc_n = '0;
          time_n  = GAME_BCD;
        end
      end
      PLAY: begin
        if (START) begin
          score_n = '0;
          presc_n = '0;
          time_n  = GAME_BCD;
        end else begin
          if (basket_evt && SCORE != 8'h99) begin
            score_n  = bcd_inc(SCORE);
            basket_n = 1'b1;
          end
          if (presc == PW'(CLK_HZ - 1)) begin
            presc_n = '0;
            time_n  = bcd_dec(TIME_LEFT);
            if (TIME_LEFT == 8'h01) state_n = OVER;
          end else begin
            presc_n = presc + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      presc     <= '0;
      TIME_LEFT <= GAME_BCD;
    end else begin
      presc     <= presc_n;
      TIME_LEFT <= time_n;
    end
  end
`else
  always_comb begin
    state_n  = state;
    score_n  = SCORE;
    basket_n = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_n = PLAY;
          score_n = '0;
        end
      end
      PLAY: begin
        if (START) begin
          score_n = '0;
        end else if (basket_evt && SCORE != 8'h99) begin
          score_n  = bcd_inc(SCORE);
          basket_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign TIME_LEFT = 8'h00;
`endif

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      SCORE   <= '0;
      BASKET  <= 1'b0;
      PLAYING <= 1'b0;
    end else begin
      state   <= state_n;
      SCORE   <= score_n;
      BASKET  <= basket_n;
      PLAYING <= (state_n == PLAY);
    end
  end

endmodule
